// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - MEM-stage data memory controller with byte lanes, faults and wait states
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   req               access request, only sampled while idle
//   we                1 = store, 0 = load
//   byte_op           1 = byte access, 0 = full-word access
//   sign_ext          byte loads: 1 = sign-extend, 0 = zero-extend
//   addr              byte address from the ALU
//   write_data        store data (byte stores use [7:0])
//   read_data         registered load result, held until the next good load
//   ready             one-cycle completion pulse
//   busy              high while a transaction is in flight
//   fault             one-cycle pulse with ready for a rejected access
module data_mem_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic              byte_op,
  input  logic              sign_ext,
  input  logic [15:0]       addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              ready,
  output logic              busy,
  output logic              fault
);

  localparam int         LSB      = $clog2(DATA_W / 8);
  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic                byte_op_q, byte_op_d;
  logic                sign_ext_q, sign_ext_d;
  logic                flag_q, flag_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [LSB-1:0]      lane_q, lane_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   read_data_q, read_data_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                fault_q, fault_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Request decode. The address is widened by one bit so the range check
  // stays well defined even when the array covers the full 16-bit space.
  logic [16:0]         addr_ext;
  logic [ADDR_W-1:0]   req_idx;
  logic [LSB-1:0]      req_lane;
  logic                req_oor;
  logic                req_misalign;
  logic                req_fault;

  assign addr_ext     = {1'b0, addr};
  assign req_idx      = ADDR_W'(addr_ext >> LSB);
  assign req_lane     = addr[LSB-1:0];
  assign req_oor      = (addr_ext >> (ADDR_W + LSB)) != 17'd0;
  assign req_misalign = !byte_op && (req_lane != '0);
  assign req_fault    = req_oor || req_misalign;

  // Datapath for the access performed on the completion edge.
  logic [DATA_W-1:0]   mem_word;
  logic [7:0]          lane_byte;
  logic [DATA_W-1:0]   byte_ext;
  logic [DATA_W-1:0]   store_word;
  logic                commit;

  assign mem_word  = mem[idx_q];
  assign lane_byte = mem_word[{lane_q, 3'b000} +: 8];
  assign byte_ext  = sign_ext_q ? {{(DATA_W-8){lane_byte[7]}}, lane_byte}
                                : {{(DATA_W-8){1'b0}}, lane_byte};
  assign commit    = (state_q == S_DONE) && !flag_q;

  // Byte stores merge into the current word so the other lanes survive.
  always_comb begin
    store_word = wdata_q;
    if (byte_op_q) begin
      store_word = mem_word;
      store_word[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    byte_op_d   = byte_op_q;
    sign_ext_d  = sign_ext_q;
    flag_d      = flag_q;
    idx_d       = idx_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;
    ready_d     = 1'b0;
    fault_d     = 1'b0;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d       = we;
          byte_op_d  = byte_op;
          sign_ext_d = sign_ext;
          flag_d     = req_fault;
          idx_d      = req_idx;
          lane_d     = req_lane;
          wdata_d    = write_data;
          busy_d     = 1'b1;
          // Faults skip the wait states entirely.
          if (req_fault || (WAIT_STATES == 0)) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        fault_d = flag_q;
        busy_d  = 1'b0;
        if (commit && !we_q) begin
          read_data_d = byte_op_q ? byte_ext : mem_word;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      byte_op_q   <= 1'b0;
      sign_ext_q  <= 1'b0;
      flag_q      <= 1'b0;
      idx_q       <= '0;
      lane_q      <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      byte_op_q   <= byte_op_d;
      sign_ext_q  <= sign_ext_d;
      flag_q      <= flag_d;
      idx_q       <= idx_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      fault_q     <= fault_d;
    end
  end

  // Array is not reset; a reset on the completion edge suppresses the commit.
  always_ff @(posedge clk) begin
    if (!reset && commit && we_q) begin
      mem[idx_q] <= store_word;
    end
  end

  assign read_data = read_data_q;
  assign ready     = ready_q;
  assign busy      = busy_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed scoreboard bench for data_mem_ctrl (WAIT_STATES 0 and 3)
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst0, rst1;
  logic        req0, req1;
  logic        we, byte_op, sign_ext;
  logic [15:0] addr, write_data;
  logic [15:0] rd0, rd1;
  logic        rdy0, rdy1, busy0, busy1, flt0, flt1;

  typedef struct {
    logic [15:0] rd;
    logic        flt;
  } sb_t;

  sb_t         sb0[$];
  sb_t         sb1[$];
  logic [15:0] last_rd [2];
  int          n_cmp = 0;
  int          n_mis = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DATA_W(16), .ADDR_W(9), .WAIT_STATES(0)) u0 (
    .clk(clk), .reset(rst0), .req(req0), .we(we), .byte_op(byte_op),
    .sign_ext(sign_ext), .addr(addr), .write_data(write_data),
    .read_data(rd0), .ready(rdy0), .busy(busy0), .fault(flt0)
  );

  data_mem_ctrl #(.DATA_W(16), .ADDR_W(9), .WAIT_STATES(3)) u1 (
    .clk(clk), .reset(rst1), .req(req1), .we(we), .byte_op(byte_op),
    .sign_ext(sign_ext), .addr(addr), .write_data(write_data),
    .read_data(rd1), .ready(rdy1), .busy(busy1), .fault(flt1)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sample(input int inst, output logic [15:0] rd, output logic r,
                        output logic b, output logic f);
    if (inst == 0) begin rd = rd0; r = rdy0; b = busy0; f = flt0; end
    else           begin rd = rd1; r = rdy1; b = busy1; f = flt1; end
  endtask

  task automatic set_req(input int inst, input logic v);
    if (inst == 0) req0 = v; else req1 = v;
  endtask

  // Called at the negedge after the accept edge; returns at the negedge after ready.
  task automatic wait_done(input int inst, input int exp_lat, input string tag);
    int          lat = 0;
    int          bc  = 0;
    logic        got = 1'b0;
    logic [15:0] rd;
    logic        r, b, f;
    sb_t         e;
    for (int i = 0; i < 40; i++) begin
      sample(inst, rd, r, b, f);
      if (b) bc++;
      @(posedge clk);
      lat++;
      @(negedge clk);
      sample(inst, rd, r, b, f);
      if (r) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, " ready_seen"}, 16'(got), 16'd1);
    check({tag, " latency"}, 16'(lat), 16'(exp_lat));
    check({tag, " busy_cycles"}, 16'(bc), 16'(exp_lat));
    check({tag, " busy_at_ready"}, 16'(b), 16'd0);
    if (inst == 0) check({tag, " sb_nonempty"}, 16'(sb0.size() > 0), 16'd1);
    else           check({tag, " sb_nonempty"}, 16'(sb1.size() > 0), 16'd1);
    if ((inst == 0 && sb0.size() > 0) || (inst == 1 && sb1.size() > 0)) begin
      e = (inst == 0) ? sb0.pop_front() : sb1.pop_front();
      check({tag, " fault"}, 16'(f), 16'(e.flt));
      check({tag, " read_data"}, rd, e.rd);
    end
  endtask

  task automatic push(input int inst, input logic [15:0] rd, input logic flt);
    sb_t e;
    e.rd  = rd;
    e.flt = flt;
    if (inst == 0) sb0.push_back(e); else sb1.push_back(e);
  endtask

  task automatic drive(input logic w, input logic b, input logic s,
                       input logic [15:0] a, input logic [15:0] wd);
    we = w; byte_op = b; sign_ext = s; addr = a; write_data = wd;
  endtask

  // Full access; load_val is the expected result of a good load.
  task automatic access(input int inst, input logic w, input logic b, input logic s,
                        input logic [15:0] a, input logic [15:0] wd,
                        input logic [15:0] load_val, input logic exp_f,
                        input int exp_lat, input string tag);
    logic [15:0] rd;
    logic        r, bz, f;
    if (!w && !exp_f) last_rd[inst] = load_val;
    push(inst, last_rd[inst], exp_f);
    @(negedge clk);
    drive(w, b, s, a, wd);
    set_req(inst, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_req(inst, 1'b0);
    // Inputs moving after acceptance must not affect the access.
    drive(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
    wait_done(inst, exp_lat, tag);
    @(posedge clk);
    @(negedge clk);
    sample(inst, rd, r, bz, f);
    check({tag, " ready_pulse"}, 16'(r), 16'd0);
    check({tag, " fault_pulse"}, 16'(f), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] rd;
    logic        r, b, f;
    int          seen;
    rst0 = 1'b1; rst1 = 1'b1; req0 = 1'b0; req1 = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    last_rd[0] = 16'h0;
    last_rd[1] = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sample(i, rd, r, b, f);
      check($sformatf("reset%0d read_data", i), rd, 16'h0);
      check($sformatf("reset%0d ready", i), 16'(r), 16'd0);
      check($sformatf("reset%0d busy", i), 16'(b), 16'd0);
      check($sformatf("reset%0d fault", i), 16'(f), 16'd0);
    end

    // WAIT_STATES = 0
    access(0, 1, 0, 0, 16'h0010, 16'hBEEF, 16'h0, 0, 1, "ws0_store_beef");
    access(0, 0, 0, 0, 16'h0010, 16'h0,    16'hBEEF, 0, 1, "ws0_load_beef");
    access(0, 1, 0, 0, 16'h0020, 16'h1234, 16'h0, 0, 1, "store_1234");
    access(0, 1, 1, 0, 16'h0021, 16'h55AB, 16'h0, 0, 1, "bstore_ab");
    access(0, 0, 0, 0, 16'h0020, 16'h0,    16'hAB34, 0, 1, "load_ab34");
    access(0, 0, 1, 1, 16'h0021, 16'h0,    16'hFFAB, 0, 1, "bload_sx1_hi");
    access(0, 0, 1, 0, 16'h0021, 16'h0,    16'h00AB, 0, 1, "bload_sx0_hi");
    access(0, 0, 1, 1, 16'h0020, 16'h0,    16'h0034, 0, 1, "bload_sx1_lo");
    access(0, 0, 0, 0, 16'h0021, 16'h0,    16'h0,    1, 1, "fault_misalign");
    access(0, 1, 0, 0, 16'h0000, 16'h7777, 16'h0, 0, 1, "store_word0");
    access(0, 1, 0, 0, 16'h0400, 16'h9999, 16'h0, 1, 1, "fault_range");
    access(0, 0, 0, 0, 16'h0000, 16'h0,    16'h7777, 0, 1, "load_word0");

    // WAIT_STATES = 3
    access(1, 1, 0, 0, 16'h0030, 16'h1111, 16'h0, 0, 4, "ws3_store_1111");
    access(1, 1, 0, 0, 16'h0401, 16'h2222, 16'h0, 1, 1, "ws3_fault_fast");

    // Request held high across a whole transaction.
    last_rd[1] = 16'h1111;
    push(1, 16'h1111, 1'b0);
    push(1, 16'h1111, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0030, 16'h0);
    req1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_done(1, 4, "hold_first");
    @(posedge clk);
    @(negedge clk);
    req1 = 1'b0;
    check("hold_reaccept busy", 16'(busy1), 16'd1);
    wait_done(1, 4, "hold_second");
    @(posedge clk);
    @(negedge clk);

    // Reset two edges into a store.
    drive(1'b1, 1'b0, 1'b0, 16'h0030, 16'h5555);
    req1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst1 = 1'b0;
    last_rd[1] = 16'h0;
    check("abort read_data", rd1, 16'h0);
    check("abort busy", 16'(busy1), 16'd0);
    check("abort fault", 16'(flt1), 16'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rdy1) seen++;
    end
    check("abort no_ready", 16'(seen), 16'd0);
    access(1, 0, 0, 0, 16'h0030, 16'h0, 16'h1111, 0, 4, "abort_no_commit");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
